sb_trans_gen_param: RTL and testbench
=====================================

SB_TRANS_GEN_PARAM -- requirements
Module: sb_trans_gen_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum AT data bytes per transaction (1..127).
REQ-002 SHALL have parameter SYM_PERIOD, default 10, sb_clk cycles each symbol is held on trans (>=2).
REQ-003 SHALL have ports, one clock and one reset; reset is asynchronous and active-high:
  sb_clk  in  1  sideband clock
  rst  in  1  asynchronous active-high reset
  start  in  1  one-cycle request, sampled only in IDLE
  trans_type  in  2  0=LT, 1=AT read cmd, 2=AT write cmd, 3=AT read response
  lse_sym  in  8  LSE byte for LT
  addr  in  8  AT address
  len  in  7  AT data length in bytes
  data  in  MAX_LEN*8  AT payload, byte 0 = data[7:0]
  disconnect_sbtx  in  1  force disconnect
  tdisconnect_tx_min  in  1  minimum disconnect time elapsed
  trans  out  10  current symbol {1'b1, byte, 1'b0}
  sym_strobe  out  1  high on first cycle of each new symbol
  trans_state  out  2  0=disconnected, 1=idle, 2=transmitting
  busy  out  1  high from accepted start until frame end
  trans_sent  out  1  one-cycle pulse after last ETX/CLSE symbol completes
  trans_err  out  1  one-cycle pulse on rejected start or abort

Function
REQ-004 SHALL implement states DISCONNECT, IDLE, DLE1, STX, LSE, CLSE, ADDR, LEN, DATA, CRC_LO, CRC_HI, DLE2, ETX, plus a STUFF sub-phase.
REQ-005 DISCONNECT: trans=10'h000, trans_state=0; exit to IDLE when disconnect_sbtx=0 and tdisconnect_tx_min=1.
REQ-006 disconnect_sbtx=1 in any state SHALL enter DISCONNECT next cycle; mid-frame entry pulses trans_err, no trans_sent.
REQ-007 IDLE: trans=10'h3FF, trans_state=1, busy=0.
REQ-008 start in IDLE SHALL latch all inputs; the first DLE symbol (byte 0xFE) appears on trans the next cycle with sym_strobe=1.
REQ-009 start outside IDLE SHALL be ignored (no error, no latch).
REQ-010 Reject when trans_type is 2 or 3 and len=0 or len>MAX_LEN: pulse trans_err next cycle, stay in IDLE.
REQ-011 Each symbol SHALL be held exactly SYM_PERIOD cycles; a symbol counter wraps SYM_PERIOD-1 -> 0 and advances the FSM on wrap.
REQ-012 LT frame: DLE(0xFE), LSE(lse_sym), CLSE(~lse_sym); no CRC, no stuffing.
REQ-013 AT frame: DLE, STX (0x05 for types 1/2, 0x04 for type 3), addr, {len, rw} (rw=1 for type 2, else 0), data bytes, CRC_LO, CRC_HI, DLE, ETX(0x40).
REQ-014 Data phase: types 2 and 3 send len bytes, byte 0 first; type 1 sends none.
REQ-015 CRC: CRC-16, polynomial 0x8005, init 0xFFFF, bytewise LSB-first, over STX through last data byte, unstuffed; CRC_LO=crc[7:0] then CRC_HI=crc[15:8].
REQ-016 Stuffing: any addr, len, data or CRC byte equal to 0xFE SHALL be sent twice consecutively; CRC counts it once.
REQ-017 trans_state=2 and busy=1 from the first DLE until ETX/CLSE finishes; then IDLE, trans_sent pulses the same cycle trans returns to 10'h3FF.
REQ-018 Back-to-back: start in the cycle after trans_sent SHALL be accepted.
REQ-019 Data byte counter SHALL be $clog2(MAX_LEN+1) bits; the last data byte is index len-1.

Reset
REQ-020 rst=1 SHALL asynchronously force DISCONNECT, trans=0, trans_state=0, sym_strobe=0, busy=0, trans_sent=0, trans_err=0, counters=0, CRC=0xFFFF.
REQ-021 Reset mid-frame SHALL discard the frame; after release, operation starts from DISCONNECT.

Verification
REQ-022 Type 0, lse_sym=0x80 -> symbols 0xFE, 0x80, 0x7F, each 10 cycles, then trans_sent, trans=10'h3FF.
REQ-023 Type 1, addr=0x4E, len=3 -> 0xFE, 0x05, 0x4E, 0x06, CRC_LO, CRC_HI, 0xFE, 0x40; CRC matches the model.
REQ-024 Type 3, addr=0x4E, len=3, data=0xFE1234 -> the 0xFE data byte is sent twice; total 12 symbols; CRC ignores the stuffed copy.
REQ-025 Type 2, len=0 or len=9 with MAX_LEN=8 -> trans_err pulse, no symbols, state stays IDLE.
REQ-026 disconnect_sbtx=1 during DATA -> trans=0 next cycle, trans_err pulse; IDLE only after tdisconnect_tx_min=1 and disconnect_sbtx=0.
REQ-027 rst pulse mid-frame, then SYM_PERIOD=4 build -> all outputs at reset values, then correct 4-cycle symbols on the next start.

Source files
------------

// File: rtl/sb_trans_gen_param.sv
// Sideband transaction generator. Serialises LT and AT frames into 10-bit
// symbols {1'b1, byte, 1'b0}. Each symbol is held for SYM_PERIOD cycles.
// AT frames carry a CRC-16 and duplicate any 0xFE payload byte.
module sb_trans_gen_param #(
    parameter int MAX_LEN    = 8,
    parameter int SYM_PERIOD = 10
) (
    input  logic                 sb_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           trans_type,
    input  logic [7:0]           lse_sym,
    input  logic [7:0]           addr,
    input  logic [6:0]           len,
    input  logic [MAX_LEN*8-1:0] data,
    input  logic                 disconnect_sbtx,
    input  logic                 tdisconnect_tx_min,
    output logic [9:0]           trans,
    output logic                 sym_strobe,
    output logic [1:0]           trans_state,
    output logic                 busy,
    output logic                 trans_sent,
    output logic                 trans_err
);

    localparam int CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SYM_PERIOD - 1);
    localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);
    localparam logic [7:0]    DLE_B    = 8'hFE;
    localparam logic [7:0]    STX_CMD  = 8'h05;
    localparam logic [7:0]    STX_RSP  = 8'h04;
    localparam logic [7:0]    ETX_B    = 8'h40;

    typedef enum logic [3:0] {
        S_DISCONNECT = 4'd0,
        S_IDLE       = 4'd1,
        S_DLE1       = 4'd2,
        S_STX        = 4'd3,
        S_LSE        = 4'd4,
        S_CLSE       = 4'd5,
        S_ADDR       = 4'd6,
        S_LEN        = 4'd7,
        S_DATA       = 4'd8,
        S_CRC_LO     = 4'd9,
        S_CRC_HI     = 4'd10,
        S_DLE2       = 4'd11,
        S_ETX        = 4'd12
    } state_t;

    // CRC-16 (poly 0x8005), one byte folded in with bit 0 entering first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  byte_in);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ byte_in[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t                 state_r, state_nx;
    logic                   stuff_r, stuff_nx;
    logic [CW-1:0]          cnt_r, cnt_nx;
    logic [IW-1:0]          idx_r, idx_nx;
    logic [15:0]            crc_r, crc_nx;
    logic [1:0]             type_r;
    logic [7:0]             lse_r, addr_r;
    logic [6:0]             len_r;
    logic [MAX_LEN*8-1:0]   data_r;
    logic                   latch_en_s;
    logic                   wrap_s;
    logic                   reject_s;
    logic [7:0]             cur_byte_s;
    logic [7:0]             data_byte_s;
    logic [7:0]             frame_byte_s;
    logic [9:0]             trans_nx;
    logic [1:0]             trans_state_nx;
    logic                   busy_nx, strobe_nx, sent_nx, err_nx;

    assign wrap_s     = (cnt_r == CNT_LAST);
    assign cur_byte_s = trans[8:1];
    assign reject_s   = trans_type[1] && ((len == 7'd0) || (len > LEN_MAX));

    // Next-state, counters, CRC and event pulses.
    always_comb begin
        state_nx   = state_r;
        stuff_nx   = stuff_r;
        cnt_nx     = cnt_r;
        idx_nx     = idx_r;
        crc_nx     = crc_r;
        latch_en_s = 1'b0;
        strobe_nx  = 1'b0;
        sent_nx    = 1'b0;
        err_nx     = 1'b0;
        if (disconnect_sbtx) begin
            state_nx = S_DISCONNECT;
            stuff_nx = 1'b0;
            cnt_nx   = {CW{1'b0}};
            idx_nx   = {IW{1'b0}};
            if ((state_r != S_DISCONNECT) && (state_r != S_IDLE)) begin
                err_nx = 1'b1;
            end else begin
                err_nx = 1'b0;
            end
        end else begin
            case (state_r)
                S_DISCONNECT: begin
                    if (tdisconnect_tx_min) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DISCONNECT;
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        latch_en_s = 1'b1;
                        if (reject_s) begin
                            err_nx = 1'b1;
                        end else begin
                            state_nx  = S_DLE1;
                            stuff_nx  = 1'b0;
                            cnt_nx    = {CW{1'b0}};
                            idx_nx    = {IW{1'b0}};
                            crc_nx    = 16'hFFFF;
                            strobe_nx = 1'b1;
                        end
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    if (wrap_s) begin
                        cnt_nx = {CW{1'b0}};
                        // The stuffed copy of a byte is not part of the CRC.
                        if (!stuff_r && (state_r inside {S_STX, S_ADDR, S_LEN, S_DATA})) begin
                            crc_nx = crc16_byte(crc_r, cur_byte_s);
                        end else begin
                            crc_nx = crc_r;
                        end
                        if (!stuff_r && (cur_byte_s == DLE_B) &&
                            (state_r inside {S_ADDR, S_LEN, S_DATA, S_CRC_LO, S_CRC_HI})) begin
                            stuff_nx  = 1'b1;
                            strobe_nx = 1'b1;
                        end else begin
                            stuff_nx  = 1'b0;
                            strobe_nx = 1'b1;
                            case (state_r)
                                S_DLE1:   state_nx = (type_r == 2'd0) ? S_LSE : S_STX;
                                S_LSE:    state_nx = S_CLSE;
                                S_STX:    state_nx = S_ADDR;
                                S_ADDR:   state_nx = S_LEN;
                                S_LEN: begin
                                    idx_nx   = {IW{1'b0}};
                                    state_nx = type_r[1] ? S_DATA : S_CRC_LO;
                                end
                                S_DATA: begin
                                    if (7'(idx_r) == (len_r - 7'd1)) begin
                                        state_nx = S_CRC_LO;
                                    end else begin
                                        idx_nx = idx_r + IW'(1);
                                    end
                                end
                                S_CRC_LO: state_nx = S_CRC_HI;
                                S_CRC_HI: state_nx = S_DLE2;
                                S_DLE2:   state_nx = S_ETX;
                                S_CLSE, S_ETX: begin
                                    state_nx  = S_IDLE;
                                    strobe_nx = 1'b0;
                                    sent_nx   = 1'b1;
                                end
                                default: begin
                                    state_nx  = S_IDLE;
                                    strobe_nx = 1'b0;
                                end
                            endcase
                        end
                    end else begin
                        cnt_nx = cnt_r + CW'(1);
                    end
                end
            endcase
        end
    end

    // Byte carried by the symbol belonging to the next state.
    always_comb begin
        data_byte_s  = 8'h00;
        frame_byte_s = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_nx == IW'(i)) begin
                data_byte_s = data_r[i*8 +: 8];
            end else begin
                data_byte_s = data_byte_s;
            end
        end
        case (state_nx)
            S_DLE1, S_DLE2: frame_byte_s = DLE_B;
            S_STX:          frame_byte_s = (type_r == 2'd3) ? STX_RSP : STX_CMD;
            S_LSE:          frame_byte_s = lse_r;
            S_CLSE:         frame_byte_s = ~lse_r;
            S_ADDR:         frame_byte_s = addr_r;
            S_LEN:          frame_byte_s = {len_r, (type_r == 2'd2)};
            S_DATA:         frame_byte_s = data_byte_s;
            S_CRC_LO:       frame_byte_s = crc_nx[7:0];
            S_CRC_HI:       frame_byte_s = crc_nx[15:8];
            S_ETX:          frame_byte_s = ETX_B;
            default:        frame_byte_s = 8'h00;
        endcase
    end

    // Line level, coarse state and busy derived from the next state.
    always_comb begin
        trans_nx       = 10'h000;
        trans_state_nx = 2'd0;
        busy_nx        = 1'b0;
        case (state_nx)
            S_DISCONNECT: begin
                trans_nx       = 10'h000;
                trans_state_nx = 2'd0;
                busy_nx        = 1'b0;
            end
            S_IDLE: begin
                trans_nx       = 10'h3FF;
                trans_state_nx = 2'd1;
                busy_nx        = 1'b0;
            end
            default: begin
                trans_nx       = {1'b1, frame_byte_s, 1'b0};
                trans_state_nx = 2'd2;
                busy_nx        = 1'b1;
            end
        endcase
    end

    // FSM, counters, CRC and registered outputs.
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_DISCONNECT;
            stuff_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            idx_r       <= {IW{1'b0}};
            crc_r       <= 16'hFFFF;
            trans       <= 10'h000;
            sym_strobe  <= 1'b0;
            trans_state <= 2'd0;
            busy        <= 1'b0;
            trans_sent  <= 1'b0;
            trans_err   <= 1'b0;
        end else begin
            state_r     <= state_nx;
            stuff_r     <= stuff_nx;
            cnt_r       <= cnt_nx;
            idx_r       <= idx_nx;
            crc_r       <= crc_nx;
            trans       <= trans_nx;
            sym_strobe  <= strobe_nx;
            trans_state <= trans_state_nx;
            busy        <= busy_nx;
            trans_sent  <= sent_nx;
            trans_err   <= err_nx;
        end
    end

    // Request fields captured when a start is taken in IDLE.
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            type_r <= 2'd0;
            lse_r  <= 8'h00;
            addr_r <= 8'h00;
            len_r  <= 7'd0;
            data_r <= {(MAX_LEN*8){1'b0}};
        end else if (latch_en_s) begin
            type_r <= trans_type;
            lse_r  <= lse_sym;
            addr_r <= addr;
            len_r  <= len;
            data_r <= data;
        end
    end

endmodule

// File: tb/tb_sb_trans_gen_param.sv
// Directed bench for sb_trans_gen_param: one instance at SYM_PERIOD=10 and a
// second at SYM_PERIOD=4, sharing stimulus.
module tb_sb_trans_gen_param;

    logic        sb_clk = 1'b0;
    logic        rst, start, disconnect_sbtx, tdisconnect_tx_min;
    logic [1:0]  trans_type;
    logic [7:0]  lse_sym, addr;
    logic [6:0]  len;
    logic [63:0] data;

    logic [9:0]  trans_a, trans_b;
    logic [1:0]  state_a, state_b;
    logic        strobe_a, strobe_b, busy_a, busy_b, sent_a, sent_b, err_a, err_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 sb_clk = ~sb_clk;

    sb_trans_gen_param #(.MAX_LEN(8), .SYM_PERIOD(10)) dut (
        .sb_clk(sb_clk), .rst(rst), .start(start), .trans_type(trans_type),
        .lse_sym(lse_sym), .addr(addr), .len(len), .data(data),
        .disconnect_sbtx(disconnect_sbtx), .tdisconnect_tx_min(tdisconnect_tx_min),
        .trans(trans_a), .sym_strobe(strobe_a), .trans_state(state_a),
        .busy(busy_a), .trans_sent(sent_a), .trans_err(err_a)
    );

    sb_trans_gen_param #(.MAX_LEN(8), .SYM_PERIOD(4)) dut4 (
        .sb_clk(sb_clk), .rst(rst), .start(start), .trans_type(trans_type),
        .lse_sym(lse_sym), .addr(addr), .len(len), .data(data),
        .disconnect_sbtx(disconnect_sbtx), .tdisconnect_tx_min(tdisconnect_tx_min),
        .trans(trans_b), .sym_strobe(strobe_b), .trans_state(state_b),
        .busy(busy_b), .trans_sent(sent_b), .trans_err(err_b)
    );

    logic       cap_sel = 1'b0;
    logic [9:0] c_trans;
    logic [1:0] c_state;
    logic       c_strobe, c_busy, c_sent;
    assign c_trans  = cap_sel ? trans_b  : trans_a;
    assign c_state  = cap_sel ? state_b  : state_a;
    assign c_strobe = cap_sel ? strobe_b : strobe_a;
    assign c_busy   = cap_sel ? busy_b   : busy_a;
    assign c_sent   = cap_sel ? sent_b   : sent_a;

    logic [7:0] cap_syms[$];
    int         cap_cyc[$];
    int         cap_sent;
    int         cap_bad;

    // Reference CRC-16: poly 0x8005, init 0xFFFF, each byte fed bit 0 first.
    function automatic logic [15:0] model_crc(input logic [7:0] body[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (body[k]) begin
            for (int j = 0; j < 8; j++) begin
                if (c[15] != body[k][j]) c = (c << 1) ^ 16'h8005;
                else                     c = c << 1;
            end
        end
        return c;
    endfunction

    // Pulses start and records every strobed symbol and its cycle number
    // until trans_sent (or a 400-cycle budget). Optionally pokes a second
    // start mid-frame with different fields.
    task automatic capture_frame(input logic sel, input bit poke);
        cap_sel = sel;
        cap_syms.delete();
        cap_cyc.delete();
        cap_sent = -1;
        cap_bad  = 0;
        start = 1'b1;
        @(negedge sb_clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (c_sent === 1'b1) begin
                cap_sent = cyc;
                break;
            end
            if (c_strobe === 1'b1) begin
                cap_syms.push_back(c_trans[8:1]);
                cap_cyc.push_back(cyc);
            end
            if (c_trans[9] !== 1'b1 || c_trans[0] !== 1'b0 || c_busy !== 1'b1 || c_state !== 2'd2)
                cap_bad++;
            if (poke && cyc == 3) begin
                start = 1'b1; trans_type = 2'd1; lse_sym = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge sb_clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; trans_type = 2'd0; lse_sym = 8'h00; addr = 8'h00;
        len = 7'd0; data = 64'h0; disconnect_sbtx = 1'b0; tdisconnect_tx_min = 1'b0;
        repeat (2) @(negedge sb_clk);
        vectors++;
        if (trans_a !== 10'h000) begin miscompares++; $display("FAIL reset_trans: got %h want 000", trans_a); end
        vectors++;
        if (state_a !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_a); end
        vectors++;
        if ({strobe_a, busy_a, sent_a, err_a} !== 4'b0000)
            begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {strobe_a, busy_a, sent_a, err_a}); end
    endtask

    task automatic test_connect;
        rst = 1'b0;
        repeat (2) @(negedge sb_clk);
        vectors++;
        if (state_a !== 2'd0 || trans_a !== 10'h000)
            begin miscompares++; $display("FAIL hold_disc: got state %0d trans %h want 0/000", state_a, trans_a); end
        tdisconnect_tx_min = 1'b1;
        @(negedge sb_clk);
        vectors++;
        if (state_a !== 2'd1 || trans_a !== 10'h3FF || busy_a !== 1'b0)
            begin miscompares++; $display("FAIL to_idle: got state %0d trans %h busy %b want 1/3ff/0", state_a, trans_a, busy_a); end
    endtask

    task automatic test_lt_ignore_start;
        logic [7:0] exp[$];
        trans_type = 2'd0; lse_sym = 8'h80;
        exp = {8'hFE, 8'h80, 8'h7F};
        capture_frame(1'b0, 1'b1);
        vectors++;
        if (cap_syms.size() !== exp.size()) begin miscompares++; $display("FAIL lt_count: got %0d want %0d", cap_syms.size(), exp.size()); end
        foreach (exp[k]) begin
            vectors++;
            if (k >= cap_syms.size() || cap_syms[k] !== exp[k] || cap_cyc[k] !== 1 + k*10) begin
                miscompares++; $display("FAIL lt_sym%0d: got %h@%0d want %h@%0d", k,
                    (k < cap_syms.size()) ? cap_syms[k] : 8'hxx, (k < cap_cyc.size()) ? cap_cyc[k] : -1, exp[k], 1 + k*10);
            end
        end
        vectors++;
        if (cap_sent !== 1 + exp.size()*10 || cap_bad !== 0 || trans_a !== 10'h3FF || state_a !== 2'd1)
            begin miscompares++; $display("FAIL lt_end: got sent@%0d bad %0d trans %h want sent@%0d bad 0 trans 3ff", cap_sent, cap_bad, trans_a, 1 + exp.size()*10); end
    endtask

    task automatic test_at_read_cmd;
        logic [7:0] body[$];
        logic [7:0] exp[$];
        logic [15:0] c;
        trans_type = 2'd1; addr = 8'h4E; len = 7'd3; data = 64'h0;
        body = {8'h05, 8'h4E, 8'h06};
        c = model_crc(body);
        exp = {8'hFE, 8'h05, 8'h4E, 8'h06};
        exp.push_back(c[7:0]);  if (c[7:0] == 8'hFE)  exp.push_back(8'hFE);
        exp.push_back(c[15:8]); if (c[15:8] == 8'hFE) exp.push_back(8'hFE);
        exp.push_back(8'hFE); exp.push_back(8'h40);
        capture_frame(1'b0, 1'b0);
        vectors++;
        if (cap_syms.size() !== exp.size()) begin miscompares++; $display("FAIL rdcmd_count: got %0d want %0d", cap_syms.size(), exp.size()); end
        foreach (exp[k]) begin
            vectors++;
            if (k >= cap_syms.size() || cap_syms[k] !== exp[k] || cap_cyc[k] !== 1 + k*10) begin
                miscompares++; $display("FAIL rdcmd_sym%0d: got %h want %h at cycle %0d", k,
                    (k < cap_syms.size()) ? cap_syms[k] : 8'hxx, exp[k], 1 + k*10);
            end
        end
        vectors++;
        if (cap_sent !== 1 + exp.size()*10 || cap_bad !== 0 || trans_a !== 10'h3FF)
            begin miscompares++; $display("FAIL rdcmd_end: got sent@%0d bad %0d want sent@%0d bad 0", cap_sent, cap_bad, 1 + exp.size()*10); end
    endtask

    task automatic test_at_read_rsp_stuff;
        logic [7:0] body[$];
        logic [7:0] exp[$];
        logic [15:0] c;
        trans_type = 2'd3; addr = 8'h4E; len = 7'd3; data = 64'h0000_0000_00FE_1234;
        body = {8'h04, 8'h4E, 8'h06, 8'h34, 8'h12, 8'hFE};
        c = model_crc(body);
        exp = {8'hFE, 8'h04, 8'h4E, 8'h06, 8'h34, 8'h12, 8'hFE, 8'hFE};
        exp.push_back(c[7:0]);  if (c[7:0] == 8'hFE)  exp.push_back(8'hFE);
        exp.push_back(c[15:8]); if (c[15:8] == 8'hFE) exp.push_back(8'hFE);
        exp.push_back(8'hFE); exp.push_back(8'h40);
        capture_frame(1'b0, 1'b0);
        vectors++;
        if (cap_syms.size() !== exp.size()) begin miscompares++; $display("FAIL rsp_count: got %0d want %0d", cap_syms.size(), exp.size()); end
        foreach (exp[k]) begin
            vectors++;
            if (k >= cap_syms.size() || cap_syms[k] !== exp[k] || cap_cyc[k] !== 1 + k*10) begin
                miscompares++; $display("FAIL rsp_sym%0d: got %h want %h at cycle %0d", k,
                    (k < cap_syms.size()) ? cap_syms[k] : 8'hxx, exp[k], 1 + k*10);
            end
        end
        vectors++;
        if (cap_sent !== 1 + exp.size()*10 || cap_bad !== 0 || trans_a !== 10'h3FF)
            begin miscompares++; $display("FAIL rsp_end: got sent@%0d bad %0d want sent@%0d bad 0", cap_sent, cap_bad, 1 + exp.size()*10); end
    endtask

    task automatic test_at_write_max;
        logic [7:0] body[$];
        logic [7:0] exp[$];
        logic [15:0] c;
        trans_type = 2'd2; addr = 8'hFE; len = 7'd8; data = 64'h08FE_0605_0403_0201;
        body = {8'h05, 8'hFE, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFE, 8'h08};
        c = model_crc(body);
        exp = {8'hFE, 8'h05, 8'hFE, 8'hFE, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'hFE, 8'hFE, 8'h08};
        exp.push_back(c[7:0]);  if (c[7:0] == 8'hFE)  exp.push_back(8'hFE);
        exp.push_back(c[15:8]); if (c[15:8] == 8'hFE) exp.push_back(8'hFE);
        exp.push_back(8'hFE); exp.push_back(8'h40);
        capture_frame(1'b0, 1'b0);
        vectors++;
        if (cap_syms.size() !== exp.size()) begin miscompares++; $display("FAIL wrmax_count: got %0d want %0d", cap_syms.size(), exp.size()); end
        foreach (exp[k]) begin
            vectors++;
            if (k >= cap_syms.size() || cap_syms[k] !== exp[k] || cap_cyc[k] !== 1 + k*10) begin
                miscompares++; $display("FAIL wrmax_sym%0d: got %h want %h at cycle %0d", k,
                    (k < cap_syms.size()) ? cap_syms[k] : 8'hxx, exp[k], 1 + k*10);
            end
        end
        vectors++;
        if (cap_sent !== 1 + exp.size()*10 || cap_bad !== 0 || trans_a !== 10'h3FF)
            begin miscompares++; $display("FAIL wrmax_end: got sent@%0d bad %0d want sent@%0d bad 0", cap_sent, cap_bad, 1 + exp.size()*10); end
    endtask

    task automatic test_reject;
        logic [6:0] bad_len[2];
        bad_len[0] = 7'd0;
        bad_len[1] = 7'd9;
        repeat (12) @(negedge sb_clk);
        for (int i = 0; i < 2; i++) begin
            trans_type = 2'd2; len = bad_len[i]; start = 1'b1;
            @(negedge sb_clk);
            start = 1'b0;
            vectors++;
            if (err_a !== 1'b1 || trans_a !== 10'h3FF || state_a !== 2'd1 || busy_a !== 1'b0 || strobe_a !== 1'b0)
                begin miscompares++; $display("FAIL reject_len%0d: got err %b trans %h state %0d busy %b want 1/3ff/1/0", bad_len[i], err_a, trans_a, state_a, busy_a); end
            @(negedge sb_clk);
            vectors++;
            if (err_a !== 1'b0 || state_a !== 2'd1 || strobe_a !== 1'b0)
                begin miscompares++; $display("FAIL reject_after%0d: got err %b state %0d want 0/1", bad_len[i], err_a, state_a); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        trans_type = 2'd0; lse_sym = 8'hFE;
        exp = {8'hFE, 8'hFE, 8'h01};
        capture_frame(1'b0, 1'b0);
        vectors++;
        if (cap_syms != exp || cap_sent !== 31 || cap_bad !== 0)
            begin miscompares++; $display("FAIL b2b_first: got %0d syms sent@%0d bad %0d want 3 syms fe fe 01 sent@31", cap_syms.size(), cap_sent, cap_bad); end
        lse_sym = 8'h5A;
        exp = {8'hFE, 8'h5A, 8'hA5};
        capture_frame(1'b0, 1'b0);
        vectors++;
        if (cap_syms != exp || cap_cyc.size() !== 3 || cap_sent !== 31 || cap_bad !== 0)
            begin miscompares++; $display("FAIL b2b_second: got %0d syms sent@%0d bad %0d want fe 5a a5 sent@31", cap_syms.size(), cap_sent, cap_bad); end
        vectors++;
        if (cap_cyc.size() == 3 && cap_cyc[0] !== 1)
            begin miscompares++; $display("FAIL b2b_latency: got first strobe @%0d want @1", cap_cyc[0]); end
    endtask

    task automatic test_disconnect;
        trans_type = 2'd2; addr = 8'h4E; len = 7'd3; data = 64'h0000_0000_0012_3456;
        start = 1'b1;
        @(negedge sb_clk);
        start = 1'b0;
        repeat (44) @(negedge sb_clk);
        vectors++;
        if (trans_a !== {1'b1, 8'h56, 1'b0} || state_a !== 2'd2)
            begin miscompares++; $display("FAIL disc_in_data: got trans %h state %0d want %h/2", trans_a, state_a, {1'b1, 8'h56, 1'b0}); end
        disconnect_sbtx = 1'b1; tdisconnect_tx_min = 1'b0;
        @(negedge sb_clk);
        vectors++;
        if (trans_a !== 10'h000 || state_a !== 2'd0 || err_a !== 1'b1 || sent_a !== 1'b0 || busy_a !== 1'b0)
            begin miscompares++; $display("FAIL disc_enter: got trans %h state %0d err %b sent %b busy %b want 000/0/1/0/0", trans_a, state_a, err_a, sent_a, busy_a); end
        @(negedge sb_clk);
        vectors++;
        if (err_a !== 1'b0) begin miscompares++; $display("FAIL disc_err_pulse: got err %b want 0", err_a); end
        disconnect_sbtx = 1'b0;
        repeat (3) @(negedge sb_clk);
        vectors++;
        if (state_a !== 2'd0 || trans_a !== 10'h000)
            begin miscompares++; $display("FAIL disc_wait_min: got state %0d trans %h want 0/000", state_a, trans_a); end
        tdisconnect_tx_min = 1'b1;
        @(negedge sb_clk);
        vectors++;
        if (state_a !== 2'd1 || trans_a !== 10'h3FF)
            begin miscompares++; $display("FAIL disc_exit: got state %0d trans %h want 1/3ff", state_a, trans_a); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp[$];
        repeat (12) @(negedge sb_clk);
        trans_type = 2'd0; lse_sym = 8'h3C; start = 1'b1;
        @(negedge sb_clk);
        start = 1'b0;
        repeat (14) @(negedge sb_clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({trans_a, state_a, strobe_a, busy_a, sent_a, err_a} !== 16'h0000)
            begin miscompares++; $display("FAIL rst_async_a: got trans %h state %0d flags %b want all zero", trans_a, state_a, {strobe_a, busy_a, sent_a, err_a}); end
        vectors++;
        if ({trans_b, state_b, strobe_b, busy_b, sent_b, err_b} !== 16'h0000)
            begin miscompares++; $display("FAIL rst_async_b: got trans %h state %0d flags %b want all zero", trans_b, state_b, {strobe_b, busy_b, sent_b, err_b}); end
        @(negedge sb_clk);
        rst = 1'b0;
        @(negedge sb_clk);
        vectors++;
        if (state_b !== 2'd1 || trans_b !== 10'h3FF || state_a !== 2'd1)
            begin miscompares++; $display("FAIL rst_recover: got state %0d trans %h want 1/3ff", state_b, trans_b); end
        exp = {8'hFE, 8'h3C, 8'hC3};
        capture_frame(1'b1, 1'b0);
        vectors++;
        if (cap_syms.size() !== exp.size()) begin miscompares++; $display("FAIL p4_count: got %0d want %0d", cap_syms.size(), exp.size()); end
        foreach (exp[k]) begin
            vectors++;
            if (k >= cap_syms.size() || cap_syms[k] !== exp[k] || cap_cyc[k] !== 1 + k*4) begin
                miscompares++; $display("FAIL p4_sym%0d: got %h want %h at cycle %0d", k,
                    (k < cap_syms.size()) ? cap_syms[k] : 8'hxx, exp[k], 1 + k*4);
            end
        end
        vectors++;
        if (cap_sent !== 13 || cap_bad !== 0 || trans_b !== 10'h3FF)
            begin miscompares++; $display("FAIL p4_end: got sent@%0d bad %0d trans %h want sent@13 bad 0 trans 3ff", cap_sent, cap_bad, trans_b); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_connect();
        test_lt_ignore_start();
        test_at_read_cmd();
        test_at_read_rsp_stuff();
        test_at_write_max();
        test_reject();
        test_back_to_back();
        test_disconnect();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
